// File: rtl/l1_d_ctrl_nway.sv
// N-way set-associative write-back/write-allocate L1 data-cache controller with tree-PLRU.
// Optional hit/miss/write-back counters when L1D_PERF_CNT_EN is defined.
module l1_d_ctrl_nway #(
  parameter int TAG_W = 21,
  parameter int IDX_W = 5,
  parameter int WAYS  = 2,
  localparam int WAY_W = $clog2(WAYS)
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             i_req_valid,
  input  logic             i_req_write,
  input  logic [TAG_W-1:0] i_req_tag,
  input  logic [IDX_W-1:0] i_req_index,
  input  logic             i_flush,
  input  logic             i_mem_ready,
  output logic             o_stall,
  output logic             o_hit,
  output logic             o_update,
  output logic             o_refill,
  output logic             o_mem_read,
  output logic             o_mem_write,
  output logic [IDX_W-1:0] o_mem_index,
  output logic [TAG_W-1:0] o_mem_tag,
  output logic [WAY_W-1:0] o_way
`ifdef L1D_PERF_CNT_EN
  ,
  output logic [31:0]      o_hit_cnt,
  output logic [31:0]      o_miss_cnt,
  output logic [31:0]      o_wb_cnt
`endif
);
  localparam int SETS = 2**IDX_W;
  localparam int LW   = IDX_W + WAY_W + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMP   = 3'd1;
  localparam logic [2:0] S_WB    = 3'd2;
  localparam logic [2:0] S_ALLOC = 3'd3;
  localparam logic [2:0] S_FSCAN = 3'd4;
  localparam logic [2:0] S_FWB   = 3'd5;

  logic [2:0]                            r_state;
  logic [SETS-1:0][WAYS-1:0][TAG_W-1:0]  r_tags;
  logic [SETS-1:0][WAYS-1:0]             r_valid;
  logic [SETS-1:0][WAYS-1:0]             r_dirty;
  logic [SETS-1:0][WAYS-2:0]             r_plru;
  logic [TAG_W-1:0]                      r_tag_q;
  logic [IDX_W-1:0]                      r_idx;
  logic                                  r_wr;
  logic                                  r_first;
  logic [WAY_W-1:0]                      r_victim;
  logic [LW-1:0]                         r_fline;

  logic [WAYS-1:0]  w_hit_vec;
  logic             w_any_hit;
  logic [WAY_W-1:0] w_hit_way;
  logic             w_inv_found;
  logic [WAY_W-1:0] w_inv_way;
  logic [WAY_W-1:0] w_victim;
  logic [IDX_W-1:0] w_fset;
  logic [WAY_W-1:0] w_fway;
  logic             w_fdone;

  // Heap-ordered tree: node k has children 2k+1 / 2k+2; bit 0 picks the left subtree.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] p);
    int n;
    logic b;
    logic [WAY_W-1:0] v;
    n = 0;
    v = '0;
    for (int l = 0; l < WAY_W; l++) begin
      b = 1'b0;
      for (int k = 0; k < WAYS-1; k++) if (k == n) b = p[k];
      v[WAY_W-1-l] = b;
      n = 2*n + 1 + (b ? 1 : 0);
    end
    return v;
  endfunction

  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] p,
                                                 input logic [WAY_W-1:0] w);
    logic [WAYS-2:0] q;
    int n;
    q = p;
    n = 0;
    for (int l = WAY_W-1; l >= 0; l--) begin
      for (int k = 0; k < WAYS-1; k++) if (k == n) q[k] = ~w[l];
      n = 2*n + 1 + (w[l] ? 1 : 0);
    end
    return q;
  endfunction

  always_comb begin
    w_hit_vec   = '0;
    w_hit_way   = '0;
    w_inv_found = 1'b0;
    w_inv_way   = '0;
    for (int i = 0; i < WAYS; i++)
      w_hit_vec[i] = r_valid[r_idx][i] && (r_tags[r_idx][i] == r_tag_q);
    for (int i = WAYS-1; i >= 0; i--) begin
      if (w_hit_vec[i]) w_hit_way = WAY_W'(i);
      if (!r_valid[r_idx][i]) begin
        w_inv_found = 1'b1;
        w_inv_way   = WAY_W'(i);
      end
    end
    w_any_hit = |w_hit_vec;
    w_victim  = w_inv_found ? w_inv_way : plru_victim(r_plru[r_idx]);
  end

  assign w_fset  = r_fline[IDX_W+WAY_W-1:WAY_W];
  assign w_fway  = r_fline[WAY_W-1:0];
  assign w_fdone = r_fline[LW-1];

  always_comb begin
    o_stall     = (r_state != S_IDLE);
    o_mem_read  = (r_state == S_ALLOC);
    o_mem_write = (r_state == S_WB) || (r_state == S_FWB);
    o_refill    = o_mem_read & i_mem_ready;
    o_hit       = (r_state == S_CMP) & w_any_hit;
    o_update    = o_hit & r_wr;
    o_way       = '0;
    o_mem_index = '0;
    o_mem_tag   = '0;
    case (r_state)
      S_CMP:   o_way = w_any_hit ? w_hit_way : w_victim;
      S_WB: begin
        o_way       = r_victim;
        o_mem_index = r_idx;
        o_mem_tag   = r_tags[r_idx][r_victim];
      end
      S_ALLOC: begin
        o_way       = r_victim;
        o_mem_index = r_idx;
        o_mem_tag   = r_tag_q;
      end
      S_FSCAN: o_way = w_fway;
      S_FWB: begin
        o_way       = w_fway;
        o_mem_index = w_fset;
        o_mem_tag   = r_tags[w_fset][w_fway];
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      r_state  <= S_IDLE;
      r_tags   <= '0;
      r_valid  <= '0;
      r_dirty  <= '0;
      r_plru   <= '0;
      r_tag_q  <= '0;
      r_idx    <= '0;
      r_wr     <= 1'b0;
      r_first  <= 1'b0;
      r_victim <= '0;
      r_fline  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_flush) begin
            r_fline <= '0;
            r_state <= S_FSCAN;
          end else if (i_req_valid) begin
            r_tag_q <= i_req_tag;
            r_idx   <= i_req_index;
            r_wr    <= i_req_write;
            r_first <= 1'b1;
            r_state <= S_CMP;
          end
        end
        S_CMP: begin
          r_first <= 1'b0;
          if (w_any_hit) begin
            r_plru[r_idx] <= plru_touch(r_plru[r_idx], w_hit_way);
            if (r_wr) r_dirty[r_idx][w_hit_way] <= 1'b1;
            r_state <= S_IDLE;
          end else begin
            r_victim <= w_victim;
            r_state  <= (r_valid[r_idx][w_victim] && r_dirty[r_idx][w_victim]) ? S_WB : S_ALLOC;
          end
        end
        S_WB: if (i_mem_ready) begin
          r_dirty[r_idx][r_victim] <= 1'b0;
          r_state <= S_ALLOC;
        end
        S_ALLOC: if (i_mem_ready) begin
          r_tags[r_idx][r_victim]  <= r_tag_q;
          r_valid[r_idx][r_victim] <= 1'b1;
          r_dirty[r_idx][r_victim] <= 1'b0;
          r_state <= S_CMP;
        end
        S_FSCAN: begin
          if (w_fdone) begin
            r_valid <= '0;
            r_dirty <= '0;
            r_plru  <= '0;
            r_fline <= '0;
            r_state <= S_IDLE;
          end else if (r_dirty[w_fset][w_fway]) begin
            r_state <= S_FWB;
          end else begin
            r_fline <= r_fline + LW'(1);
          end
        end
        S_FWB: if (i_mem_ready) begin
          r_dirty[w_fset][w_fway] <= 1'b0;
          r_fline <= r_fline + LW'(1);
          r_state <= S_FSCAN;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef L1D_PERF_CNT_EN
  // Only the first compare of a request is classified; the post-refill re-compare is not.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      o_hit_cnt  <= '0;
      o_miss_cnt <= '0;
      o_wb_cnt   <= '0;
    end else begin
      if (r_state == S_CMP && r_first) begin
        if (w_any_hit && o_hit_cnt != 32'hFFFF_FFFF)   o_hit_cnt  <= o_hit_cnt + 32'd1;
        if (!w_any_hit && o_miss_cnt != 32'hFFFF_FFFF) o_miss_cnt <= o_miss_cnt + 32'd1;
      end
      if (o_mem_write && i_mem_ready && o_wb_cnt != 32'hFFFF_FFFF)
        o_wb_cnt <= o_wb_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_l1_d_ctrl_nway.sv
// Directed bench for l1_d_ctrl_nway: a 2-way and a 4-way instance share one stimulus path,
// selected by sel. Perf-counter checks compile in when L1D_PERF_CNT_EN is defined.
module tb_l1_d_ctrl_nway;
  logic        clk = 1'b0;
  logic        nrst = 1'b0;
  logic        sel = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, flush = 1'b0, mem_ready = 1'b0;
  logic [20:0] req_tag = '0;
  logic [4:0]  req_index = '0;

  logic        s2_stall, s2_hit, s2_upd, s2_ref, s2_mr, s2_mw;
  logic [4:0]  s2_idx;
  logic [20:0] s2_tag;
  logic [0:0]  s2_way;
  logic        s4_stall, s4_hit, s4_upd, s4_ref, s4_mr, s4_mw;
  logic [4:0]  s4_idx;
  logic [20:0] s4_tag;
  logic [1:0]  s4_way;
`ifdef L1D_PERF_CNT_EN
  logic [31:0] c2_hit, c2_miss, c2_wb, c4_hit, c4_miss, c4_wb;
`endif

  always #5 clk = ~clk;

  l1_d_ctrl_nway #(.TAG_W(21), .IDX_W(5), .WAYS(2)) u_dut2 (
    .clk(clk), .nrst(nrst),
    .i_req_valid(req_valid & ~sel), .i_req_write(req_write), .i_req_tag(req_tag),
    .i_req_index(req_index), .i_flush(flush & ~sel), .i_mem_ready(mem_ready & ~sel),
    .o_stall(s2_stall), .o_hit(s2_hit), .o_update(s2_upd), .o_refill(s2_ref),
    .o_mem_read(s2_mr), .o_mem_write(s2_mw), .o_mem_index(s2_idx), .o_mem_tag(s2_tag),
    .o_way(s2_way)
`ifdef L1D_PERF_CNT_EN
    , .o_hit_cnt(c2_hit), .o_miss_cnt(c2_miss), .o_wb_cnt(c2_wb)
`endif
  );

  l1_d_ctrl_nway #(.TAG_W(21), .IDX_W(5), .WAYS(4)) u_dut4 (
    .clk(clk), .nrst(nrst),
    .i_req_valid(req_valid & sel), .i_req_write(req_write), .i_req_tag(req_tag),
    .i_req_index(req_index), .i_flush(flush & sel), .i_mem_ready(mem_ready & sel),
    .o_stall(s4_stall), .o_hit(s4_hit), .o_update(s4_upd), .o_refill(s4_ref),
    .o_mem_read(s4_mr), .o_mem_write(s4_mw), .o_mem_index(s4_idx), .o_mem_tag(s4_tag),
    .o_way(s4_way)
`ifdef L1D_PERF_CNT_EN
    , .o_hit_cnt(c4_hit), .o_miss_cnt(c4_miss), .o_wb_cnt(c4_wb)
`endif
  );

  wire        stall     = sel ? s4_stall : s2_stall;
  wire        hit       = sel ? s4_hit   : s2_hit;
  wire        update    = sel ? s4_upd   : s2_upd;
  wire        refill    = sel ? s4_ref   : s2_ref;
  wire        mem_read  = sel ? s4_mr    : s2_mr;
  wire        mem_write = sel ? s4_mw    : s2_mw;
  wire [4:0]  mem_index = sel ? s4_idx   : s2_idx;
  wire [20:0] mem_tag   = sel ? s4_tag   : s2_tag;
  wire [2:0]  way       = sel ? {1'b0, s4_way} : {2'b0, s2_way};

  int n_chk = 0, n_err = 0;
  int cyc, n_hit, n_upd, n_ref, n_rd, n_wb;
  logic first_hit;
  logic [31:0] upd_way, ref_way;
  logic [31:0] wb_tag [4];
  logic [31:0] wb_way [4];
  logic [31:0] wb_idx [4];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    req_valid = 1'b0; flush = 1'b0; mem_ready = 1'b0;
    nrst = 1'b0;
    @(negedge clk); @(negedge clk);
    nrst = 1'b1;
    @(negedge clk);
  endtask

  // Runs from the current negedge until stall drops, answering L2 dly cycles into each phase.
  task automatic run(input int dly);
    int wcnt;
    logic pmr, pmw;
    wcnt = 0; pmr = 1'b0; pmw = 1'b0;
    cyc = 0; n_hit = 0; n_upd = 0; n_ref = 0; n_rd = 0; n_wb = 0;
    first_hit = 1'b0; upd_way = '1; ref_way = '1;
    while (cyc < 400) begin
      if (!stall) break;
      if (mem_read || mem_write) begin
        if (wcnt == dly-1) begin mem_ready = 1'b1; wcnt = 0; end
        else begin mem_ready = 1'b0; wcnt++; end
      end else begin
        mem_ready = 1'b0; wcnt = 0;
      end
      #1;
      if (cyc == 0) first_hit = hit;
      if (hit) n_hit++;
      if (update) begin n_upd++; upd_way = 32'(way); end
      if (refill) begin n_ref++; ref_way = 32'(way); end
      if (mem_read && !pmr) n_rd++;
      if (mem_write && !pmw) begin
        if (n_wb < 4) begin
          wb_tag[n_wb] = 32'(mem_tag); wb_way[n_wb] = 32'(way); wb_idx[n_wb] = 32'(mem_index);
        end
        n_wb++;
      end
      pmr = mem_read; pmw = mem_write;
      @(negedge clk);
      cyc++;
    end
    mem_ready = 1'b0;
    chk("run_done_stall", 32'(stall), 0);
  endtask

  task automatic do_req(input logic wr, input logic [20:0] tag, input logic [4:0] idx,
                        input int dly);
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_tag = tag; req_index = idx;
    @(negedge clk);
    req_valid = 1'b0;
    run(dly);
  endtask

  initial begin
    // reset state
    nrst = 1'b0;
    #3;
    chk("rst_ctl", {26'd0, stall, hit, update, refill, mem_read, mem_write}, 0);
    chk("rst_bus", {3'd0, mem_tag, mem_index, way}, 0);
    do_reset();

    // cold load, 2-way
    do_req(1'b0, 21'h1A, 5'd3, 3);
    chk("s1_first_miss", 32'(first_hit), 0);
    chk("s1_n_read", n_rd, 1);
    chk("s1_n_refill", n_ref, 1);
    chk("s1_refill_way", ref_way, 0);
    chk("s1_recmp_hit", n_hit, 1);
    chk("s1_n_wb", n_wb, 0);

    // load 1, load 2, store 1, load 3, load 2 on set 3
    do_reset();
    do_req(1'b0, 21'h1, 5'd3, 1);
    chk("s2_l1_way", ref_way, 0);
    do_req(1'b0, 21'h2, 5'd3, 1);
    chk("s2_l2_way", ref_way, 1);
    do_req(1'b1, 21'h1, 5'd3, 1);
    chk("s2_st_hit", 32'(first_hit), 1);
    chk("s2_st_nupd", n_upd, 1);
    chk("s2_st_way", upd_way, 0);
    do_req(1'b0, 21'h3, 5'd3, 1);
    chk("s2_l3_nwb", n_wb, 0);
    chk("s2_l3_way", ref_way, 1);
    do_req(1'b0, 21'h2, 5'd3, 2);
    chk("s2_l2b_nwb", n_wb, 1);
    chk("s2_l2b_wbtag", wb_tag[0], 32'h1);
    chk("s2_l2b_wbway", wb_way[0], 0);
    chk("s2_l2b_nrd", n_rd, 1);
    chk("s2_l2b_refway", ref_way, 0);
`ifdef L1D_PERF_CNT_EN
    chk("perf_hit", c2_hit, 1);
    chk("perf_miss", c2_miss, 4);
    chk("perf_wb", c2_wb, 1);
`endif

    // flush with dirty {2,1} and {9,0}
    do_reset();
    do_req(1'b0, 21'h10, 5'd2, 1);
    do_req(1'b1, 21'h11, 5'd2, 1);
    chk("fl_st_way", upd_way, 1);
    do_req(1'b1, 21'h20, 5'd9, 1);
    @(negedge clk); flush = 1'b1;
    @(negedge clk); flush = 1'b0;
    run(2);
    chk("fl_nwb", n_wb, 2);
    chk("fl_wb0", {wb_idx[0][7:0], wb_way[0][7:0], wb_tag[0][15:0]}, {8'd2, 8'd1, 16'h11});
    chk("fl_wb1", {wb_idx[1][7:0], wb_way[1][7:0], wb_tag[1][15:0]}, {8'd9, 8'd0, 16'h20});
    do_req(1'b0, 21'h10, 5'd2, 1);
    chk("fl_miss_a", 32'(first_hit), 0);
    do_req(1'b0, 21'h20, 5'd9, 1);
    chk("fl_miss_b", 32'(first_hit), 0);

    // reset during ALLOCATE
    do_reset();
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_tag = 21'h55; req_index = 5'd7;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk);
    chk("ra_in_alloc", 32'(mem_read), 1);
    mem_ready = 1'b1;
    #1;
    chk("ra_refill_pre", 32'(refill), 1);
    nrst = 1'b0;
    #1;
    chk("ra_abort", {29'd0, stall, mem_read, refill}, 0);
    mem_ready = 1'b0;
    @(negedge clk); nrst = 1'b1;
    do_req(1'b0, 21'h55, 5'd7, 1);
    chk("ra_reload_miss", 32'(first_hit), 0);

    // 4-way PLRU victim
    sel = 1'b1;
    do_reset();
    do_req(1'b0, 21'hA, 5'd0, 1);
    chk("w4_a_way", ref_way, 0);
    do_req(1'b0, 21'hB, 5'd0, 1);
    do_req(1'b0, 21'hC, 5'd0, 1);
    chk("w4_c_way", ref_way, 2);
    do_req(1'b0, 21'hD, 5'd0, 1);
    chk("w4_d_way", ref_way, 3);
    do_req(1'b0, 21'hA, 5'd0, 1);
    chk("w4_a_hit", 32'(first_hit), 1);
    do_req(1'b0, 21'hE, 5'd0, 1);
    chk("w4_e_miss", 32'(first_hit), 0);
    chk("w4_e_way", ref_way, 2);
    chk("w4_e_nwb", n_wb, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/l1_d_ctrl_nway.md
Name: l1_d_ctrl_nway

Overview:
Parametrised N-way set-associative, write-back, write-allocate L1 data-cache controller. It holds the tag, valid, dirty and tree-PLRU state for the cache. It sequences hit, write-back, allocate and full-cache flush toward L2, and steers the external data array through way, update and refill. It sits between the core's load/store unit and the L2 interface, replacing the fixed 2-way controller.

Parameters:
TAG_W, 21, tag width in bits
IDX_W, 5, set-index width; SETS = 2**IDX_W
WAYS, 2, associativity; legal values 2, 4, 8; WAY_W = log2(WAYS)

Ports:
clk  in  1  clock
nrst  in  1  asynchronous active-low reset
req_valid  in  1  core request; sampled only in IDLE
req_write  in  1  1 = store, 0 = load
req_tag  in  TAG_W  request tag
req_index  in  IDX_W  request set
flush  in  1  write back all dirty lines, then invalidate; sampled only in IDLE
mem_ready  in  1  L2 done with the current read or write
stall  out  1  controller busy
hit  out  1  tag match in COMPARE
update  out  1  data array accepts core write data (store hit)
refill  out  1  data array accepts L2 line
mem_read  out  1  L2 line-fill request
mem_write  out  1  L2 write-back request
mem_index  out  IDX_W  set for the L2 transfer
mem_tag  out  TAG_W  tag for the L2 transfer: latched tag on a read, victim tag on a write
way  out  WAY_W  way selected for data-array access

Behaviour:
- Reset (async): state IDLE; all valid, dirty and PLRU bits 0; tags 0; flush counter 0. All outputs 0.
- Outputs decode combinationally from state and registers:
  - stall = (state != IDLE)
  - mem_read = ALLOCATE
  - mem_write = WRITE_BACK or FLUSH_WB
  - refill = ALLOCATE & mem_ready
  - update = COMPARE & hit & latched write
- IDLE:
  - flush has priority over req_valid → FLUSH_SCAN.
  - Otherwise req_valid latches tag, index and write → COMPARE.
- COMPARE (one cycle): hit = any way with valid & tag equal; way = hit way.
  - On hit: PLRU path set to point away from the hit way; dirty set on a write; → IDLE.
  - On miss: victim = lowest-numbered invalid way, else the PLRU victim. way = victim. Victim valid & dirty → WRITE_BACK, otherwise → ALLOCATE. Victim choice is the same for loads and stores.
- WRITE_BACK: mem_tag = victim tag; hold until mem_ready; then dirty[victim] = 0 → ALLOCATE.
- ALLOCATE: mem_tag = latched tag; hold until mem_ready; then tag written, valid = 1, dirty = 0 → COMPARE. The re-compare hits and sets dirty/PLRU.
- Store-hit latency is 1 cycle from acceptance to update; a store miss pulses update only after refill.
- FLUSH_SCAN: visits line L = {set, way}, L = 0 .. SETS*WAYS-1, one cycle per line.
  - Dirty line → FLUSH_WB with mem_index/way/mem_tag from L.
  - After the last line: all valid, dirty and PLRU bits cleared → IDLE.
- FLUSH_WB: hold until mem_ready; then clear dirty → FLUSH_SCAN at L+1.
- mem_ready is ignored outside WRITE_BACK, ALLOCATE and FLUSH_WB.
- req_valid and flush are ignored while stall = 1.
- Tree-PLRU: WAYS-1 bits per set. A node bit of 0 selects the left subtree as victim.
- Reset asserted mid-transfer aborts immediately; no partial tag or valid update survives.

Optional Feature:
L1D_PERF_CNT_EN
- Defined: adds outputs hit_cnt[31:0], miss_cnt[31:0], wb_cnt[31:0].
  - hit_cnt increments on the first COMPARE of a request if it hits; miss_cnt if it misses. The post-allocate re-compare is not counted.
  - wb_cnt increments on every WRITE_BACK or FLUSH_WB completion.
  - All three saturate at 0xFFFFFFFF; cleared by reset only.
- Undefined: ports and logic absent.

Test Plan:
- Cold load, WAYS=2, tag 0x1A, idx 3, mem_ready 3 cycles after mem_read → path COMPARE→ALLOCATE→COMPARE→IDLE; one refill pulse with way=0; the re-compare hits; stall drops.
- WAYS=2, idx 3, sequence: load 0x1, load 0x2, store 0x1, load 0x3, load 0x2:
  - store 0x1 → update with way=0.
  - load 0x3 evicts way1 with no write-back.
  - load 0x2 → WRITE_BACK with mem_tag=0x1, way=0, then ALLOCATE.
- Flush with dirty lines {idx2, way1} and {idx9, way0} → exactly two mem_write phases, in that order; then every valid bit is 0 and a load to either line misses.
- WAYS=4, idx 0, fill tags A, B, C, D into ways 0–3, load A, then load E → victim way2.
- nrst pulsed low during ALLOCATE → stall, mem_read and refill go 0 at once; a reload of the same tag misses.
- L1D_PERF_CNT_EN: scenario 2 → hit_cnt=1, miss_cnt=4, wb_cnt=1.
